// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus: ID-stage control inputs, flush request, and per-stage
// control/valid/rd outputs plus fetch enables, halt and stall statistics.
interface ctrl_pipe_if #(
   parameter int unsigned CTRL_W      = 12,
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned STALL_CNT_W = 16
);
   logic                   id_valid;
   logic [CTRL_W-1:0]      id_ctrl;
   logic                   id_not_halt;
   logic [REG_AW-1:0]      id_rd;
   logic [REG_AW-1:0]      id_rs1;
   logic [REG_AW-1:0]      id_rs2;
   logic                   flush;

   logic                   pc_write;
   logic                   ifid_write;
   logic                   ifid_flush;
   logic                   ex_valid;
   logic                   mem_valid;
   logic                   wb_valid;
   logic [CTRL_W-1:0]      ex_ctrl;
   logic [CTRL_W-1:0]      mem_ctrl;
   logic [CTRL_W-1:0]      wb_ctrl;
   logic [REG_AW-1:0]      ex_rd;
   logic [REG_AW-1:0]      mem_rd;
   logic [REG_AW-1:0]      wb_rd;
   logic                   halted;
   logic [STALL_CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_ctrl, id_not_halt, id_rd, id_rs1, id_rs2, flush,
      input  pc_write, ifid_write, ifid_flush,
      input  ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
      input  ex_rd, mem_rd, wb_rd, halted, stall_count
   );

   modport slave (
      input  id_valid, id_ctrl, id_not_halt, id_rd, id_rs1, id_rs2, flush,
      output pc_write, ifid_write, ifid_flush,
      output ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
      output ex_rd, mem_rd, wb_rd, halted, stall_count
   );
endinterface

// File: rtl/ctrl_pipe.sv
// Control-word pipeline ID->EX->MEM->WB with load-use stall, branch flush
// and EBREAK halt drain; drives PC / IF-ID enables back to fetch.
module ctrl_pipe #(
   parameter int unsigned CTRL_W      = 12,
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned STALL_CNT_W = 16
) (
   input logic        clk,
   input logic        rst_n,
   ctrl_pipe_if.slave bus
);
   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t                 r_state, w_state_nxt;

   logic                   r_ex_valid, r_mem_valid, r_wb_valid;
   logic [CTRL_W-1:0]      r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
   logic [REG_AW-1:0]      r_ex_rd, r_mem_rd, r_wb_rd;
   logic                   r_ex_halt, r_mem_halt, r_wb_halt;
   logic [STALL_CNT_W-1:0] r_stall_count;

   logic w_load_use;
   logic w_pc_write, w_ifid_write, w_ifid_flush;
   logic w_ex_take_id, w_mem_kill, w_all_kill, w_stall;

   assign w_load_use = bus.id_valid & r_ex_valid & r_ex_ctrl[9] & (r_ex_rd != '0) &
                       ((r_ex_rd == bus.id_rs1) | (r_ex_rd == bus.id_rs2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_RUN;
      else        r_state <= w_state_nxt;
   end

   // Priority: halted > flush > halt drain > load-use > normal issue.
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_write   = 1'b1;
      w_ifid_write = 1'b1;
      w_ifid_flush = 1'b0;
      w_ex_take_id = 1'b0;
      w_mem_kill   = 1'b0;
      w_all_kill   = 1'b0;
      w_stall      = 1'b0;
      if (r_state == S_HALTED) begin
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_all_kill   = 1'b1;
      end else if (bus.flush) begin
         w_ifid_flush = 1'b1;
         w_mem_kill   = 1'b1;
         if (r_ex_halt) w_state_nxt = S_RUN;
      end else if (r_state == S_DRAIN) begin
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
      end else if (w_load_use) begin
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_stall      = 1'b1;
      end else begin
         w_ex_take_id = 1'b1;
         if (bus.id_valid && !bus.id_not_halt) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_state_nxt  = S_DRAIN;
         end
      end
      // A marker only reaches wb via a surviving drain, so retire wins here.
      if (r_state != S_HALTED && r_wb_halt) w_state_nxt = S_HALTED;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid <= 1'b0; r_ex_ctrl <= '0; r_ex_rd <= '0; r_ex_halt <= 1'b0;
      end else if (w_ex_take_id && bus.id_valid) begin
         r_ex_valid <= 1'b1;
         r_ex_ctrl  <= bus.id_ctrl;
         r_ex_rd    <= bus.id_rd;
         r_ex_halt  <= ~bus.id_not_halt;
      end else begin
         r_ex_valid <= 1'b0; r_ex_ctrl <= '0; r_ex_rd <= '0; r_ex_halt <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_valid <= 1'b0; r_mem_ctrl <= '0; r_mem_rd <= '0; r_mem_halt <= 1'b0;
      end else if (w_all_kill || w_mem_kill) begin
         r_mem_valid <= 1'b0; r_mem_ctrl <= '0; r_mem_rd <= '0; r_mem_halt <= 1'b0;
      end else begin
         r_mem_valid <= r_ex_valid;
         r_mem_ctrl  <= r_ex_ctrl;
         r_mem_rd    <= r_ex_rd;
         r_mem_halt  <= r_ex_halt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid <= 1'b0; r_wb_ctrl <= '0; r_wb_rd <= '0; r_wb_halt <= 1'b0;
      end else if (w_all_kill) begin
         r_wb_valid <= 1'b0; r_wb_ctrl <= '0; r_wb_rd <= '0; r_wb_halt <= 1'b0;
      end else begin
         r_wb_valid <= r_mem_valid;
         r_wb_ctrl  <= r_mem_ctrl;
         r_wb_rd    <= r_mem_rd;
         r_wb_halt  <= r_mem_halt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               r_stall_count <= '0;
      else if (w_stall && r_stall_count != '1) r_stall_count <= r_stall_count + STALL_CNT_W'(1);
   end

   assign bus.pc_write    = w_pc_write;
   assign bus.ifid_write  = w_ifid_write;
   assign bus.ifid_flush  = w_ifid_flush;
   assign bus.ex_valid    = r_ex_valid;
   assign bus.mem_valid   = r_mem_valid;
   assign bus.wb_valid    = r_wb_valid;
   assign bus.ex_ctrl     = r_ex_ctrl;
   assign bus.mem_ctrl    = r_mem_ctrl;
   assign bus.wb_ctrl     = r_wb_ctrl;
   assign bus.ex_rd       = r_ex_rd;
   assign bus.mem_rd      = r_mem_rd;
   assign bus.wb_rd       = r_wb_rd;
   assign bus.halted      = (r_state == S_HALTED);
   assign bus.stall_count = r_stall_count;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: issue, load-use stall, flush, halt drain,
// mid-run reset and stall counter saturation (narrow counter instance).
module tb_ctrl_pipe;
   localparam int unsigned CW  = 12;
   localparam int unsigned AW  = 5;
   localparam int unsigned SCW = 8;

   localparam logic [CW-1:0] C_RTYPE = 12'h042;
   localparam logic [CW-1:0] C_LOAD  = 12'h6C0;
   localparam logic [CW-1:0] C_BR    = 12'h801;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   ctrl_pipe_if #(.CTRL_W(CW), .REG_AW(AW), .STALL_CNT_W(SCW)) bus ();
   ctrl_pipe #(.CTRL_W(CW), .REG_AW(AW), .STALL_CNT_W(SCW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [CW-1:0] c, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic nh);
      bus.id_valid    = v;
      bus.id_ctrl     = c;
      bus.id_rd       = rd;
      bus.id_rs1      = rs1;
      bus.id_rs2      = rs2;
      bus.id_not_halt = nh;
      #1;
   endtask

   initial begin
      bus.flush = 1'b0;
      set_id(1'b0, '0, '0, '0, '0, 1'b1);
      tick(); tick();
      chk("rst_ex_valid", bus.ex_valid, 0);
      chk("rst_mem_valid", bus.mem_valid, 0);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_wb_ctrl", bus.wb_ctrl, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_stall", bus.stall_count, 0);
      chk("rst_pc_write", bus.pc_write, 1);
      chk("rst_ifid_write", bus.ifid_write, 1);
      chk("rst_ifid_flush", bus.ifid_flush, 0);
      rst_n = 1'b1;

      // Four back-to-back R-type instructions
      for (int i = 1; i <= 4; i++) begin
         set_id(1'b1, C_RTYPE, AW'(i), '0, '0, 1'b1);
         chk("rt_pc_write", bus.pc_write, 1);
         tick();
         chk("rt_ex_rd", bus.ex_rd, i);
         chk("rt_ex_ctrl", bus.ex_ctrl, C_RTYPE);
         if (i >= 2) chk("rt_mem_rd", bus.mem_rd, i - 1);
         if (i >= 3) chk("rt_wb_rd", bus.wb_rd, i - 2);
      end
      set_id(1'b0, '0, '0, '0, '0, 1'b1);
      tick();
      chk("rt_drain_ex_valid", bus.ex_valid, 0);
      chk("rt_drain_mem_rd", bus.mem_rd, 4);
      chk("rt_drain_wb_rd", bus.wb_rd, 3);
      tick();
      chk("rt_wb_rd4", bus.wb_rd, 4);
      chk("rt_stall0", bus.stall_count, 0);
      tick();

      // Load-use stall
      set_id(1'b1, C_LOAD, 5'd5, '0, '0, 1'b1);
      chk("ld_pc_write", bus.pc_write, 1);
      tick();
      chk("ld_ex_ctrl", bus.ex_ctrl, C_LOAD);
      set_id(1'b1, C_RTYPE, 5'd6, 5'd5, 5'd7, 1'b1);
      chk("lu_pc_write", bus.pc_write, 0);
      chk("lu_ifid_write", bus.ifid_write, 0);
      tick();
      chk("lu_ex_bubble", bus.ex_valid, 0);
      chk("lu_ex_ctrl0", bus.ex_ctrl, 0);
      chk("lu_mem_rd", bus.mem_rd, 5);
      chk("lu_stall1", bus.stall_count, 1);
      chk("lu_pc_resume", bus.pc_write, 1);
      tick();
      chk("lu_ex_rd6", bus.ex_rd, 6);
      chk("lu_ex_valid", bus.ex_valid, 1);
      set_id(1'b1, C_LOAD, 5'd0, '0, '0, 1'b1);
      tick();
      set_id(1'b1, C_RTYPE, 5'd7, 5'd0, 5'd0, 1'b1);
      chk("x0_no_stall", bus.pc_write, 1);
      tick();
      chk("x0_ex_rd7", bus.ex_rd, 7);
      chk("x0_stall_same", bus.stall_count, 1);
      set_id(1'b0, '0, '0, '0, '0, 1'b1);
      tick(); tick(); tick();

      // Flush with branch in mem
      set_id(1'b1, C_BR, 5'd0, 5'd1, 5'd2, 1'b1);
      tick();
      set_id(1'b1, C_RTYPE, 5'd8, 5'd1, 5'd1, 1'b1);
      tick();
      chk("fl_mem_br", bus.mem_ctrl, C_BR);
      set_id(1'b1, C_RTYPE, 5'd9, 5'd1, 5'd1, 1'b1);
      bus.flush = 1'b1;
      #1;
      chk("fl_ifid_flush", bus.ifid_flush, 1);
      chk("fl_pc_write", bus.pc_write, 1);
      chk("fl_ifid_write", bus.ifid_write, 1);
      tick();
      chk("fl_wb_ctrl", bus.wb_ctrl, C_BR);
      chk("fl_wb_valid", bus.wb_valid, 1);
      chk("fl_mem_bubble", bus.mem_valid, 0);
      chk("fl_ex_bubble", bus.ex_valid, 0);
      chk("fl_ex_rd0", bus.ex_rd, 0);
      bus.flush = 1'b0;
      set_id(1'b0, '0, '0, '0, '0, 1'b1);
      chk("fl_ifid_flush_off", bus.ifid_flush, 0);
      tick(); tick();

      // Load-use coinciding with flush
      set_id(1'b1, C_BR, 5'd0, '0, '0, 1'b1);
      tick();
      set_id(1'b1, C_LOAD, 5'd3, '0, '0, 1'b1);
      tick();
      set_id(1'b1, C_RTYPE, 5'd10, 5'd3, 5'd0, 1'b1);
      bus.flush = 1'b1;
      #1;
      chk("lf_pc_write", bus.pc_write, 1);
      chk("lf_ifid_flush", bus.ifid_flush, 1);
      tick();
      chk("lf_stall_same", bus.stall_count, 1);
      chk("lf_ex_bubble", bus.ex_valid, 0);
      chk("lf_mem_bubble", bus.mem_valid, 0);
      chk("lf_wb_br", bus.wb_ctrl, C_BR);
      bus.flush = 1'b0;
      set_id(1'b0, '0, '0, '0, '0, 1'b1);
      tick(); tick(); tick();

      // EBREAK in ex killed by flush
      set_id(1'b1, C_BR, 5'd0, '0, '0, 1'b1);
      tick();
      set_id(1'b1, '0, 5'd0, '0, '0, 1'b0);
      chk("ek_accept_pc", bus.pc_write, 0);
      tick();
      chk("ek_ex_valid", bus.ex_valid, 1);
      set_id(1'b0, '0, '0, '0, '0, 1'b1);
      chk("ek_pending_pc", bus.pc_write, 0);
      bus.flush = 1'b1;
      #1;
      chk("ek_flush_pc", bus.pc_write, 1);
      chk("ek_flush_ifid", bus.ifid_flush, 1);
      tick();
      chk("ek_ex_bubble", bus.ex_valid, 0);
      chk("ek_mem_bubble", bus.mem_valid, 0);
      chk("ek_wb_br", bus.wb_ctrl, C_BR);
      bus.flush = 1'b0;
      #1;
      chk("ek_resume_pc", bus.pc_write, 1);
      tick(); tick(); tick(); tick();
      chk("ek_not_halted", bus.halted, 0);
      chk("ek_pc_after", bus.pc_write, 1);

      // EBREAK drains and halts
      set_id(1'b1, 12'h003, 5'd0, '0, '0, 1'b0);
      chk("eb_pc_write", bus.pc_write, 0);
      chk("eb_ifid_write", bus.ifid_write, 0);
      tick();
      chk("eb_ex_ctrl", bus.ex_ctrl, 12'h003);
      chk("eb_ex_valid", bus.ex_valid, 1);
      chk("eb_pend_pc", bus.pc_write, 0);
      tick();
      chk("eb_mem_ctrl", bus.mem_ctrl, 12'h003);
      chk("eb_ex_bubble", bus.ex_valid, 0);
      tick();
      chk("eb_wb_ctrl", bus.wb_ctrl, 12'h003);
      chk("eb_not_yet", bus.halted, 0);
      chk("eb_wb_pc", bus.pc_write, 0);
      tick();
      chk("eb_halted", bus.halted, 1);
      chk("eb_h_pc", bus.pc_write, 0);
      chk("eb_h_ifid", bus.ifid_write, 0);
      set_id(1'b1, C_RTYPE, 5'd12, '0, '0, 1'b1);
      bus.flush = 1'b1;
      #1;
      chk("eb_h_flush_ign", bus.ifid_flush, 0);
      chk("eb_h_flush_pc", bus.pc_write, 0);
      tick();
      chk("eb_h_sticky", bus.halted, 1);
      chk("eb_h_ex_bubble", bus.ex_valid, 0);
      chk("eb_h_wb_bubble", bus.wb_valid, 0);
      bus.flush = 1'b0;

      // Mid-run reset clears immediately
      set_id(1'b0, '0, '0, '0, '0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mr_halted", bus.halted, 0);
      chk("mr_pc_write", bus.pc_write, 1);
      chk("mr_stall", bus.stall_count, 0);
      tick();
      rst_n = 1'b1;

      // Self-dependent load stalls every other cycle; counter saturates
      set_id(1'b1, C_LOAD, 5'd5, 5'd5, 5'd0, 1'b1);
      for (int i = 0; i < 100; i++) tick();
      chk("sat_mid", bus.stall_count, 50);
      for (int i = 0; i < 410; i++) tick();
      chk("sat_full", bus.stall_count, 8'hFF);
      for (int i = 0; i < 10; i++) tick();
      chk("sat_hold", bus.stall_count, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receives the decoded control word from the ID-stage control unit and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers, together with rd and a halt marker.
- Owns load-use stall detection, bubble insertion, flush on a taken branch/jump, and halt drain on EBREAK.
- Drives PC and IF/ID write enables back to fetch.
- Sits between the control unit and the datapath stage registers.

Parameters:
CTRL_W, 12, control word width: [11]branch [10]MemtoReg [9]MemRead [8]MemWrite [7]ALUSrc [6]RegWrite [5]jalr [4]auipc [3]jal [2]lui [1:0]ALUOp
REG_AW, 5, register address width
STALL_CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_ctrl  in  CTRL_W  control word from control unit
id_not_halt  in  1  isnot_halt from control unit (0 = EBREAK)
id_rd, id_rs1, id_rs2  in  REG_AW each  ID register fields
flush  in  1  instruction in MEM stage is a taken branch/jump
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register update enable
ifid_flush  out  1  clear IF/ID to bubble
ex_valid, mem_valid, wb_valid  out  1 each  stage valid
ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W each  stage control words
ex_rd, mem_rd, wb_rd  out  REG_AW each  stage destination registers
halted  out  1  sticky, EBREAK retired
stall_count  out  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (async, rst_n=0): all valid=0, ctrl=0, rd=0, stage halt markers=0, halt_pending=0, halted=0, stall_count=0. Combinational outputs then read pc_write=1, ifid_write=1, ifid_flush=0.
- Bubble: valid=0, ctrl=0, rd=0, halt marker=0.
- load_use (combinational) = id_valid & ex_valid & ex_ctrl[9] & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Priority per cycle: halted > flush > halt_pending > load_use > normal.
- Normal: ex<=ID (bubble if id_valid=0), mem<=ex, wb<=mem. pc_write=1, ifid_write=1.
- Stall (load_use):
  - ex<=bubble; mem and wb advance.
  - pc_write=0, ifid_write=0.
  - stall_count+=1, saturating at all-ones.
  - Stalls are exactly one cycle per load-use pair.
- Flush:
  - wb<=mem (the branch retires); mem<=bubble; ex<=bubble.
  - ifid_flush=1, pc_write=1, ifid_write=1.
  - load_use is ignored.
  - If the ex-stage halt marker is set, halt_pending clears and fetch resumes.
- Halt accept:
  - Condition: id_valid & ~id_not_halt, with no flush and no load_use.
  - EBREAK enters ex with ctrl as supplied and halt marker=1; halt_pending<=1.
  - pc_write=0 and ifid_write=0 combinationally in the accepting cycle.
- halt_pending=1: ex<=bubble every cycle; pc_write=0, ifid_write=0; mem and wb advance; the marker travels ex->mem->wb.
- Retire: the cycle after wb halt marker=1, halted<=1 (sticky until reset). Afterwards all stages load bubbles, pc_write=0, ifid_write=0, ifid_flush=0, and flush is ignored.
- A flush while the halt marker is in mem or wb has no effect on it (only younger stages are killed).
- ECALL (id_not_halt=1, opcode SYSTEM) is a normal instruction.
- rd is carried unchanged; x0 writes are not suppressed here.
- Reset asserted mid-operation clears all state immediately; there is no drain.

Test Plan:
- Reset, then 4 back-to-back R-type (RegWrite=1, ALUOp=10, rd=1..4) -> each appears in ex/mem/wb on 1/2/3 cycles after ID, pc_write stays 1, stall_count=0.
- Load rd=5 (ctrl MemRead/MemtoReg/ALUSrc/RegWrite) followed by ADD rs1=5 -> one bubble in ex, pc_write=ifid_write=0 for exactly 1 cycle, stall_count=1; rd=0 load followed by user of x0 -> no stall.
- Branch in mem with flush=1, younger instructions in ex and ID -> next cycle wb=branch, mem=bubble, ex=bubble, ifid_flush=1.
- EBREAK in ID -> pc_write=0 same cycle; marker reaches wb 3 cycles later; halted=1 on the next edge; later flush pulses change nothing.
- EBREAK in ex with flush=1 -> marker killed, halt_pending cleared, pc_write=1, halted never asserts.
- Load-use and flush in the same cycle -> flush behaviour only, stall_count unchanged; 65536+ stall cycles -> stall_count holds at 0xFFFF.
